// File: rtl/rf_write_sequencer.sv
// Burst write sequencer for the latch-based register file. It turns a start command
// and a valid/ready word stream into registered single-word writes (waddr/wdata/we).
// Optional feature macro: RF_WRITE_SEQ_CLEAR_EN adds clear_i and a CLEAR state that zero-fills the RF.
//
// state | meaning
// IDLE  | waiting for start_i (or clear_i when enabled)
// LOAD  | accepting stream words, one RF write per handshake
// DONE  | one-cycle done_o pulse, then back to IDLE
// CLEAR | writing zero to every address (RF_WRITE_SEQ_CLEAR_EN only)
module rf_write_sequencer #(
  parameter int AddrWidth = 4,
  parameter int DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth:0]   num_words_i,
  input  logic                 abort_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DataWidth-1:0] s_data_i,
  output logic [AddrWidth-1:0] waddr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 we_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef RF_WRITE_SEQ_CLEAR_EN
  ,
  input  logic                 clear_i
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
`ifdef RF_WRITE_SEQ_CLEAR_EN
  localparam logic [1:0] CLEAR = 2'd3;
`endif

  localparam logic [AddrWidth:0] NumWordsW = {1'b1, {AddrWidth{1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth:0]   rem_q, rem_d;
  logic [AddrWidth-1:0] waddr_q, waddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [AddrWidth:0]   num_clamped;

  assign num_clamped = (num_words_i > NumWordsW) ? NumWordsW : num_words_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = num_clamped;
          state_d = (num_clamped == '0) ? DONE : LOAD;
        end
`ifdef RF_WRITE_SEQ_CLEAR_EN
        else if (clear_i) begin
          addr_d  = '0;
          rem_d   = NumWordsW;
          state_d = CLEAR;
        end
`endif
      end
      LOAD: begin
        // s_ready_o is the state decode, so a valid in LOAD is a handshake
        if (s_valid_i) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data_i;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == 1) state_d = DONE;
        end
        if (abort_i) state_d = IDLE;
      end
      DONE: state_d = IDLE;
`ifdef RF_WRITE_SEQ_CLEAR_EN
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = '0;
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        if (rem_q == 1) state_d = DONE;
        if (abort_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign s_ready_o = (state_q == LOAD);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;
  assign we_o      = we_q;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Scoreboard bench for rf_write_sequencer: the driver queues expected RF writes and
// done pulses, a negedge monitor pops and compares whatever the DUT presents.
module tb_rf_write_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, abort_i, s_valid_i;
  logic [3:0]  base_addr_i;
  logic [4:0]  num_words_i;
  logic [15:0] s_data_i;
  logic        s_ready_o, we_o, busy_o, done_o;
  logic [3:0]  waddr_o;
  logic [15:0] wdata_o;
`ifdef RF_WRITE_SEQ_CLEAR_EN
  logic        clear_i;
`endif

  rf_write_sequencer #(.AddrWidth(4), .DataWidth(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .abort_i(abort_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .s_data_i(s_data_i), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .we_o(we_o), .busy_o(busy_o), .done_o(done_o)
`ifdef RF_WRITE_SEQ_CLEAR_EN
    , .clear_i(clear_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_mem [16] = '{default: 16'h0};
  logic [15:0] rf [16] = '{default: 16'h0};
  logic [3:0]  last_a = '0;
  logic [15:0] last_d = '0;
  int          nvec = 0;
  int          nmis = 0;

  // downstream RF model fed by the DUT outputs, used for readback
  always @(posedge clk_i) if (we_o) rf[waddr_o] <= wdata_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (we_o || done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {we_o, done_o}, 2'b00);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("we", we_o, e.we);
          chk("done", done_o, e.done);
          if (e.we) begin
            chk("waddr", waddr_o, e.addr);
            chk("wdata", wdata_o, e.data);
            last_a = e.addr;
            last_d = e.data;
          end
        end
        if (done_o) chk("ready_in_done", s_ready_o, 1'b0);
      end else begin
        chk("hold_waddr", waddr_o, last_a);
        chk("hold_wdata", wdata_o, last_d);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (busy_o) chk("idle_timeout", busy_o, 1'b0);
  endtask

  // called at a negedge; abort_beat < 0 means no abort
  task automatic run_burst(input logic [3:0] base, input logic [4:0] num,
                           input logic [15:0] seed, input logic [31:0] gap_mask,
                           input int abort_beat, input logic ign_start);
    int n, n_send, idx, cyc;
    logic vld, rdy;
    exp_t e;
    wait_idle();
    n = (num > 16) ? 16 : int'(num);
    n_send = (abort_beat >= 0) ? abort_beat + 1 : n;
    if (n == 0) begin
      e.we = 1'b0; e.addr = '0; e.data = '0; e.done = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < n_send; i++) begin
        e.we = 1'b1;
        e.addr = base + 4'(i);
        e.data = seed + 16'(i);
        e.done = (abort_beat < 0) && (i == n - 1);
        exp_q.push_back(e);
        exp_mem[e.addr] = e.data;
      end
    end
    start_i = 1'b1; base_addr_i = base; num_words_i = num;
    @(negedge clk_i);
    start_i = 1'b0;
    base_addr_i = 4'h0; num_words_i = 5'd7;
    if (n == 0) return;
    chk("busy_after_start", busy_o, 1'b1);
    idx = 0; cyc = 0;
    while (idx < n_send && cyc < 200) begin
      vld = !gap_mask[cyc % 32];
      s_valid_i = vld;
      s_data_i = seed + 16'(idx);
      start_i = ign_start;
      abort_i = (abort_beat >= 0) && (idx == abort_beat) && vld;
      rdy = s_ready_o;
      chk("ready_in_load", rdy, 1'b1);
      @(negedge clk_i);
      if (vld && rdy) idx++;
      cyc++;
    end
    s_valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
    if (idx < n_send) chk("stream_timeout", idx, n_send);
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, rf[i], exp_mem[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; s_valid_i = 1'b0;
    base_addr_i = '0; num_words_i = '0; s_data_i = '0;
`ifdef RF_WRITE_SEQ_CLEAR_EN
    clear_i = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    chk("rst_we", we_o, 1'b0);
    chk("rst_waddr", waddr_o, 4'h0);
    chk("rst_wdata", wdata_o, 16'h0);
    chk("rst_ready", s_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // basic burst, valid held high
    run_burst(4'd3, 5'd4, 16'hA000, 32'h0, -1, 1'b0);
    wait_idle();
    readback("rb_basic");

    // wrap-around
    run_burst(4'd14, 5'd4, 16'hB000, 32'h0, -1, 1'b0);
    // empty burst
    run_burst(4'd9, 5'd0, 16'h0, 32'h0, -1, 1'b0);
    // oversize clamps to 16
    run_burst(4'd5, 5'd31, 16'hC000, 32'h0, -1, 1'b0);
    wait_idle();
    readback("rb_oversize");

    // backpressure gaps with a stray start_i held during LOAD
    run_burst(4'd8, 5'd6, 16'hD000, 32'b0000_0000_0000_0000_0101_1001_1010_0110, -1, 1'b1);

    // abort on 2nd beat of a 5-word burst, then restart right away
    run_burst(4'd2, 5'd5, 16'hE000, 32'h0, 1, 1'b0);
    chk("busy_after_abort", busy_o, 1'b0);
    run_burst(4'd9, 5'd2, 16'hF000, 32'h0, -1, 1'b0);
    wait_idle();
    @(negedge clk_i);
    readback("rb_abort");

`ifdef RF_WRITE_SEQ_CLEAR_EN
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      e.we = 1'b1; e.addr = 4'(i); e.data = 16'h0; e.done = (i == 15);
      exp_q.push_back(e);
      exp_mem[i] = 16'h0;
    end
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("ready_in_clear", s_ready_o, 1'b0);
    wait_idle();
    @(negedge clk_i);
    readback("rb_clear");
`endif

    // asynchronous reset right after a write is presented
    wait_idle();
    start_i = 1'b1; base_addr_i = 4'd0; num_words_i = 5'd3;
    @(negedge clk_i);
    start_i = 1'b0; s_valid_i = 1'b1; s_data_i = 16'hDEAD;
    @(posedge clk_i);
    #1;
    chk("pre_rst_we", we_o, 1'b1);
    chk("pre_rst_wdata", wdata_o, 16'hDEAD);
    rst_ni = 1'b0; last_a = '0; last_d = '0;
    #1;
    chk("async_rst_we", we_o, 1'b0);
    chk("async_rst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    readback("rb_final");

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk_i);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
